interp_sched: RTL

Round-robin scheduler that feeds setpoint updates from several requesters into one `interpon` interpolation channel. It produces the periodic `strobe`/`y_in` pair the interpolator requires, grants one pending request per period, and holds the last value when nothing is pending. It also latches the interpolator's `timing_error`/`data_error` into sticky status bits for the host. It sits between the host/feedforward setpoint sources and the `interpon` instance.

---
 rtl/interp_sched_pkg.sv | 18 +
 rtl/interp_sched_rr_arbiter.sv | 34 +++
 rtl/interp_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/interp_sched_pkg.sv
// Shared constants and parameter legality check for the interpon setpoint scheduler.
package interp_sched_pkg;

    localparam int unsigned YW         = 17;
    localparam int unsigned SW         = 16;
    localparam int unsigned MIN_PERIOD = 20;
    localparam int unsigned MAX_PERIOD = 511;
    localparam logic [SW-1:0] STARVE_MAX = '1;

    // Period must clear the interpolator's serial multiply and fit in the counter.
    function automatic bit params_ok(input int unsigned period, input int unsigned cntw,
                                     input int unsigned nreq, input int unsigned idw);
        return (period >= MIN_PERIOD) && (period <= MAX_PERIOD) &&
               (cntw >= 1) && (cntw < 32) && (period <= (32'd1 << cntw)) &&
               (nreq >= 2) && (nreq <= 8) && (idw < 32) && (nreq <= (32'd1 << idw));
    endfunction

endpackage

// File: rtl/interp_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned nreq = 4,
    parameter int unsigned idw  = 2
) (
    input  logic [nreq-1:0] req,
    input  logic [idw-1:0]  ptr,
    input  logic            en,
    output logic [nreq-1:0] gnt,
    output logic [idw-1:0]  gnt_id,
    output logic            any
);

    always_comb begin
        int unsigned base;
        logic [idw-1:0] sel;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        base   = 32'(ptr);
        sel    = '0;
        if (en) begin
            for (int unsigned k = 0; k < nreq; k++) begin
                sel = idw'((base + k) % nreq);
                if (!any && req[sel]) begin
                    any      = 1'b1;
                    gnt[sel] = 1'b1;
                    gnt_id   = sel;
                end
            end
        end
    end

endmodule

// File: rtl/interp_sched.sv
// Round-robin setpoint scheduler producing the periodic strobe/y_in pair for interpon,
// plus sticky interpolator error status and a starvation counter.
module interp_sched
    import interp_sched_pkg::*;
#(
    parameter int unsigned nreq   = 4,
    parameter int unsigned idw    = 2,
    parameter int unsigned period = 51,
    parameter int unsigned cntw   = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [nreq-1:0]      req_valid,
    input  logic [YW*nreq-1:0]   req_data,
    output logic [nreq-1:0]      req_ready,
    output logic [YW-1:0]        y_in,
    output logic                 strobe,
    output logic [idw-1:0]       grant_id,
    output logic                 fresh,
    input  logic                 timing_error,
    input  logic                 data_error,
    input  logic                 err_clear,
    output logic                 sticky_timing,
    output logic                 sticky_data,
    output logic [SW-1:0]        starve_count
);

    if (!params_ok(period, cntw, nreq, idw)) begin : g_bad_params
        $error("interp_sched: illegal parameter combination");
    end

    localparam logic [cntw-1:0] CNT_LAST = cntw'(period - 1);
    localparam logic [idw-1:0]  PTR_LAST = idw'(nreq - 1);

    logic [cntw-1:0] cnt;
    logic [idw-1:0]  ptr;
    logic [YW-1:0]   data_reg;
    logic            tick;
    logic [nreq-1:0] gnt;
    logic [idw-1:0]  gnt_id;
    logic            any;
    logic [YW-1:0]   gnt_data;
    logic            multi;
    logic            starve_inc;

    // Gating tick by enable suppresses a tick whose cycle coincides with enable falling.
    assign tick = enable && (cnt == CNT_LAST);

    rr_arbiter #(
        .nreq (nreq),
        .idw  (idw)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (tick),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign req_ready = gnt;
    assign y_in      = data_reg;

    always_comb begin
        int unsigned nvalid;
        gnt_data = '0;
        nvalid   = 0;
        for (int unsigned i = 0; i < nreq; i++) begin
            if (gnt[i]) begin
                gnt_data = gnt_data | req_data[i*YW +: YW];
            end
            if (req_valid[i]) begin
                nvalid = nvalid + 1;
            end
        end
        multi = (nvalid >= 2);
    end

    assign starve_inc = tick && multi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // y_in is data_reg itself: it only changes on the tick edge, i.e. with the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe   <= 1'b0;
            fresh    <= 1'b0;
            data_reg <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            strobe <= tick;
            fresh  <= tick && any;
            if (tick && any) begin
                data_reg <= gnt_data;
                grant_id <= gnt_id;
                ptr      <= (gnt_id == PTR_LAST) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_timing <= 1'b0;
            sticky_data   <= 1'b0;
        end else begin
            if (timing_error) begin
                sticky_timing <= 1'b1;
            end else if (err_clear) begin
                sticky_timing <= 1'b0;
            end
            if (data_error) begin
                sticky_data <= 1'b1;
            end else if (err_clear) begin
                sticky_data <= 1'b0;
            end
        end
    end

    // A clear coinciding with an increment leaves the count at 1 rather than 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_count <= '0;
        end else if (err_clear) begin
            starve_count <= starve_inc ? SW'(1) : '0;
        end else if (starve_inc && starve_count != STARVE_MAX) begin
            starve_count <= starve_count + 1'b1;
        end
    end

endmodule
